// File: rtl/logic_capture_pkg.sv
// Shared definitions for the logic capture command responder:
// function codes, status bit positions, FSM states and config defaults.
package logic_capture_pkg;

    localparam logic [7:0] CMD_NOP      = 8'h00;
    localparam logic [7:0] CMD_START    = 8'h01;
    localparam logic [7:0] CMD_ABORT    = 8'h02;
    localparam logic [7:0] CMD_TRIG_CFG = 8'h03;
    localparam logic [7:0] CMD_BUF_CFG  = 8'h04;
    localparam logic [7:0] CMD_RD_DATA  = 8'h05;
    localparam logic [7:0] CMD_RD_SIZE  = 8'h06;
    localparam logic [7:0] CMD_RD_TRIG  = 8'h07;
    localparam logic [7:0] CMD_ACK      = 8'h08;
    localparam logic [7:0] CMD_RESET    = 8'h09;

    localparam int STAT_CAP_IDLE  = 0;
    localparam int STAT_CAP_TRIG  = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_ACK       = 3;
    localparam int STAT_ERROR     = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_EXEC      = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_ACK_WAIT  = 2'd3
    } state_t;

    localparam logic [31:0] PRE_RST       = 32'h0000_0000;
    localparam logic [31:0] TOTAL_RST     = 32'h0000_0000;
    localparam logic [15:0] PATTERN_RST   = 16'h0000;
    localparam logic [15:0] ACTIVE_RST    = 16'hFFFF;
    localparam logic [15:0] DONT_CARE_RST = 16'hFFFF;
    localparam logic [7:0]  EDGE_CH_RST   = 8'h00;

endpackage

// File: rtl/logic_capture_cfg_regs.sv
// Buffer and trigger configuration registers; a write only lands when the
// payload passes validation, otherwise the matching reject flag is raised.
module logic_capture_cfg_regs
    import logic_capture_pkg::*;
#(
    parameter int NUM_CH = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_buf_we,
    input  logic        i_trig_we,
    input  logic        i_clear,
    input  logic        i_cap_idle,
    input  logic [63:0] i_data,
    output logic        o_buf_reject,
    output logic        o_trig_reject,
    output logic [31:0] o_pre,
    output logic [31:0] o_total,
    output logic [15:0] o_pattern,
    output logic [15:0] o_active_ch,
    output logic [15:0] o_dont_care,
    output logic [7:0]  o_edge_ch,
    output logic        o_edge_type,
    output logic        o_edge_en,
    output logic        o_pattern_en
);

    localparam logic [8:0] NUM_CH_W = 9'(NUM_CH);

    logic [31:0] r_pre, r_total;
    logic [15:0] r_pattern, r_active_ch, r_dont_care;
    logic [7:0]  r_edge_ch;
    logic        r_edge_type, r_edge_en, r_pattern_en;

    assign o_buf_reject  = (i_data[63:32] > i_data[31:0]) || (i_data[31:0] == 32'h0)
                           || !i_cap_idle;
    assign o_trig_reject = ({1'b0, i_data[55:48]} >= NUM_CH_W) || !i_cap_idle;

    // Config storage: reset/clear to defaults, validated writes otherwise.
    always_ff @(posedge clk) begin
        if (!resetn || i_clear) begin
            r_pre        <= PRE_RST;
            r_total      <= TOTAL_RST;
            r_pattern    <= PATTERN_RST;
            r_active_ch  <= ACTIVE_RST;
            r_dont_care  <= DONT_CARE_RST;
            r_edge_ch    <= EDGE_CH_RST;
            r_edge_type  <= 1'b0;
            r_edge_en    <= 1'b0;
            r_pattern_en <= 1'b0;
        end else begin
            if (i_buf_we && !o_buf_reject) begin
                r_pre   <= i_data[63:32];
                r_total <= i_data[31:0];
            end
            if (i_trig_we && !o_trig_reject) begin
                r_pattern    <= i_data[15:0];
                r_active_ch  <= i_data[31:16];
                r_dont_care  <= i_data[47:32];
                r_edge_ch    <= i_data[55:48];
                r_pattern_en <= i_data[56];
                r_edge_en    <= i_data[57];
                r_edge_type  <= i_data[58];
            end
        end
    end

    assign o_pre        = r_pre;
    assign o_total      = r_total;
    assign o_pattern    = r_pattern;
    assign o_active_ch  = r_active_ch;
    assign o_dont_care  = r_dont_care;
    assign o_edge_ch    = r_edge_ch;
    assign o_edge_type  = r_edge_type;
    assign o_edge_en    = r_edge_en;
    assign o_pattern_en = r_pattern_en;

endmodule

// File: rtl/logic_capture_cmd_responder.sv
// Target end of the hub command/register protocol: decodes function codes,
// drives capture config and control pulses, returns results, runs the ack handshake.
module logic_capture_cmd_responder
    import logic_capture_pkg::*;
#(
    parameter int RD_TIMEOUT = 1024,
    parameter int NUM_CH     = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  command,
    input  logic        commandStrobe,
    input  logic [63:0] regIn,
    output logic [63:0] regOut,
    output logic [7:0]  status,
    input  logic        cap_idle,
    input  logic        cap_triggered,
    input  logic [31:0] trigger_sample,
    input  logic [31:0] trace_size,
    output logic        trace_rd_req,
    input  logic        trace_rd_valid,
    input  logic [63:0] trace_rd_data,
    output logic        start_pulse,
    output logic        abort_pulse,
    output logic        soft_reset_pulse,
    output logic [31:0] pre_trigger_count,
    output logic [31:0] total_sample_count,
    output logic [15:0] pattern,
    output logic [15:0] active_ch,
    output logic [15:0] dont_care,
    output logic [7:0]  edge_ch,
    output logic        edge_type,
    output logic        edge_en,
    output logic        pattern_en
);

    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

    state_t            r_state, w_next_state;
    logic [7:0]        r_cmd;
    logic [63:0]       r_reg_in, r_reg_out;
    logic [CNT_W-1:0]  r_to_cnt;
    logic              r_ack, r_error, r_busy, r_cap_idle, r_cap_trig;
    logic              r_start, r_abort, r_soft, r_rd_req;

    logic              w_accept, w_timeout, w_buf_we, w_trig_we, w_cfg_clear;
    logic              w_buf_rej, w_trig_rej, w_start, w_abort, w_soft, w_rd_req;
    logic              w_ack_set, w_ack_clr, w_err_set, w_err_clr, w_out_load;
    logic [63:0]       w_out_data;

    assign w_accept  = (r_state == ST_IDLE) && commandStrobe && (command != CMD_ACK);
    assign w_timeout = (r_to_cnt == CNT_W'(RD_TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:      w_next_state = w_accept ? ST_EXEC : ST_IDLE;
            ST_EXEC:      w_next_state = (r_cmd == CMD_RD_DATA) ? ST_WAIT_DATA : ST_ACK_WAIT;
            ST_WAIT_DATA: w_next_state = (trace_rd_valid || w_timeout) ? ST_ACK_WAIT : ST_WAIT_DATA;
            ST_ACK_WAIT:  w_next_state = (commandStrobe && command == CMD_ACK) ? ST_IDLE : ST_ACK_WAIT;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    // Per-state actions; all results are registered in the datapath block.
    always_comb begin
        w_buf_we = 1'b0;  w_trig_we = 1'b0;  w_cfg_clear = 1'b0;
        w_start  = 1'b0;  w_abort   = 1'b0;  w_soft      = 1'b0;  w_rd_req = 1'b0;
        w_ack_set = 1'b0; w_ack_clr = 1'b0;  w_err_set   = 1'b0;  w_err_clr = 1'b0;
        w_out_load = 1'b0; w_out_data = 64'h0;
        case (r_state)
            ST_IDLE: w_err_clr = w_accept;
            ST_EXEC: begin
                w_ack_set = (r_cmd != CMD_RD_DATA);
                case (r_cmd)
                    CMD_NOP:      w_err_set = 1'b0;
                    CMD_START:    begin w_start = cap_idle; w_err_set = !cap_idle; end
                    CMD_ABORT:    w_abort = 1'b1;
                    CMD_RESET:    begin w_soft = 1'b1; w_abort = 1'b1; w_cfg_clear = 1'b1; end
                    CMD_BUF_CFG:  begin w_buf_we = 1'b1; w_err_set = w_buf_rej; end
                    CMD_TRIG_CFG: begin w_trig_we = 1'b1; w_err_set = w_trig_rej; end
                    CMD_RD_DATA:  w_rd_req = 1'b1;
                    CMD_RD_SIZE:  begin w_out_load = 1'b1; w_out_data = {32'h0, trace_size}; end
                    CMD_RD_TRIG:  begin w_out_load = 1'b1; w_out_data = {32'h0, trigger_sample}; end
                    default:      w_err_set = 1'b1;
                endcase
            end
            ST_WAIT_DATA: begin
                if (trace_rd_valid) begin
                    w_out_load = 1'b1; w_out_data = trace_rd_data; w_ack_set = 1'b1;
                end else if (w_timeout) begin
                    w_out_load = 1'b1; w_err_set = 1'b1; w_ack_set = 1'b1;
                end else begin
                    w_out_load = 1'b0;
                end
            end
            ST_ACK_WAIT: begin
                if (commandStrobe) begin
                    w_ack_clr = (command == CMD_ACK);
                    w_err_set = (command != CMD_ACK);
                end else begin
                    w_ack_clr = 1'b0;
                end
            end
            default: w_err_set = 1'b0;
        endcase
    end

    // Datapath: command latch, result register, handshake flags and pulses.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cmd <= 8'h00;       r_reg_in <= 64'h0;   r_reg_out <= 64'h0;
            r_to_cnt <= '0;       r_ack <= 1'b0;       r_error <= 1'b0;
            r_busy <= 1'b0;       r_cap_idle <= 1'b0;  r_cap_trig <= 1'b0;
            r_start <= 1'b0;      r_abort <= 1'b0;     r_soft <= 1'b0;
            r_rd_req <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cmd    <= command;
                r_reg_in <= regIn;
            end
            if (w_out_load) begin
                r_reg_out <= w_out_data;
            end
            r_to_cnt   <= (r_state == ST_WAIT_DATA) ? r_to_cnt + CNT_W'(1) : '0;
            r_ack      <= w_ack_set ? 1'b1 : (w_ack_clr ? 1'b0 : r_ack);
            r_error    <= w_err_clr ? 1'b0 : (w_err_set ? 1'b1 : r_error);
            r_busy     <= (w_next_state != ST_IDLE);
            r_cap_idle <= cap_idle;
            r_cap_trig <= cap_triggered;
            r_start    <= w_start;
            r_abort    <= w_abort;
            r_soft     <= w_soft;
            r_rd_req   <= w_rd_req;
        end
    end

    logic_capture_cfg_regs #(.NUM_CH(NUM_CH)) u_cfg_regs (
        .clk          (clk),
        .resetn       (resetn),
        .i_buf_we     (w_buf_we),
        .i_trig_we    (w_trig_we),
        .i_clear      (w_cfg_clear),
        .i_cap_idle   (cap_idle),
        .i_data       (r_reg_in),
        .o_buf_reject (w_buf_rej),
        .o_trig_reject(w_trig_rej),
        .o_pre        (pre_trigger_count),
        .o_total      (total_sample_count),
        .o_pattern    (pattern),
        .o_active_ch  (active_ch),
        .o_dont_care  (dont_care),
        .o_edge_ch    (edge_ch),
        .o_edge_type  (edge_type),
        .o_edge_en    (edge_en),
        .o_pattern_en (pattern_en)
    );

    always_comb begin
        status                = 8'h00;
        status[STAT_CAP_IDLE] = r_cap_idle;
        status[STAT_CAP_TRIG] = r_cap_trig;
        status[STAT_BUSY]     = r_busy;
        status[STAT_ACK]      = r_ack;
        status[STAT_ERROR]    = r_error;
    end

    assign regOut           = r_reg_out;
    assign trace_rd_req     = r_rd_req;
    assign start_pulse      = r_start;
    assign abort_pulse      = r_abort;
    assign soft_reset_pulse = r_soft;

endmodule

// File: tb/tb_logic_capture_cmd_responder.sv
// Directed bench for the command responder: hub-side command sequences with
// a trace source model that answers read requests three clocks later.
module tb_logic_capture_cmd_responder;

    localparam logic [7:0] C_NOP = 8'h00, C_START = 8'h01, C_TRIG = 8'h03, C_BUF = 8'h04;
    localparam logic [7:0] C_RDD = 8'h05, C_RDS = 8'h06, C_RDT = 8'h07, C_ACK = 8'h08;
    localparam logic [7:0] C_RST = 8'h09;

    logic        clk = 1'b0, resetn = 1'b0;
    logic [7:0]  command = 8'h00;
    logic        commandStrobe = 1'b0;
    logic [63:0] regIn = 64'h0, regOut;
    logic [7:0]  status;
    logic        cap_idle = 1'b1, cap_triggered = 1'b0;
    logic [31:0] trigger_sample = 32'd0, trace_size = 32'd0;
    logic        trace_rd_req, trace_rd_valid;
    logic [63:0] trace_rd_data;
    logic        start_pulse, abort_pulse, soft_reset_pulse;
    logic [31:0] pre_trigger_count, total_sample_count;
    logic [15:0] pattern, active_ch, dont_care;
    logic [7:0]  edge_ch;
    logic        edge_type, edge_en, pattern_en;

    int n_checks = 0, n_errors = 0;
    int n_start = 0, n_abort = 0, n_soft = 0, tr_idx = 0, lat = 0;
    logic [2:0] dly = 3'b000;
    logic       resp_en = 1'b1;

    always #5 clk = ~clk;

    logic_capture_cmd_responder #(.RD_TIMEOUT(1024), .NUM_CH(16)) dut (
        .clk(clk), .resetn(resetn), .command(command), .commandStrobe(commandStrobe),
        .regIn(regIn), .regOut(regOut), .status(status), .cap_idle(cap_idle),
        .cap_triggered(cap_triggered), .trigger_sample(trigger_sample),
        .trace_size(trace_size), .trace_rd_req(trace_rd_req),
        .trace_rd_valid(trace_rd_valid), .trace_rd_data(trace_rd_data),
        .start_pulse(start_pulse), .abort_pulse(abort_pulse),
        .soft_reset_pulse(soft_reset_pulse), .pre_trigger_count(pre_trigger_count),
        .total_sample_count(total_sample_count), .pattern(pattern),
        .active_ch(active_ch), .dont_care(dont_care), .edge_ch(edge_ch),
        .edge_type(edge_type), .edge_en(edge_en), .pattern_en(pattern_en)
    );

    function automatic logic [63:0] trace_word(input int i);
        return {32'hDA7A_0000 + 32'(i), 32'h1234_5678 ^ 32'(i * 7)};
    endfunction

    assign trace_rd_valid = dly[2] && resp_en;
    assign trace_rd_data  = trace_word(tr_idx);

    // Trace source model and pulse counters.
    always @(posedge clk) begin
        dly <= {dly[1:0], trace_rd_req};
        if (trace_rd_valid)   tr_idx  <= tr_idx + 1;
        if (start_pulse)      n_start <= n_start + 1;
        if (abort_pulse)      n_abort <= n_abort + 1;
        if (soft_reset_pulse) n_soft  <= n_soft + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [7:0] code, input logic [63:0] data);
        @(negedge clk);
        command = code; regIn = data; commandStrobe = 1'b1;
        @(posedge clk); #1;
        commandStrobe = 1'b0; command = 8'h00;
    endtask

    // Issue a command and wait (bounded) for ack; lat = edges after the strobe edge.
    task automatic issue(input logic [7:0] code, input logic [63:0] data);
        strobe(code, data);
        lat = 0;
        while (!status[3] && lat < 1200) begin
            @(posedge clk); #1; lat++;
        end
        if (!status[3]) chk("ack_timeout", 64'(status[3]), 64'd1);
    endtask

    task automatic ack_cmd();
        strobe(C_ACK, 64'h0);
        chk("ack_clear", 64'(status[3]), 64'd0);
        chk("busy_clear", 64'(status[2]), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_status", 64'(status), 64'h00);
        chk("rst_active", 64'(active_ch), 64'hFFFF);
        chk("rst_dontcare", 64'(dont_care), 64'hFFFF);
        chk("rst_regout", regOut, 64'h0);
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
        chk("cap_idle_copy", 64'(status[0]), 64'd1);

        // BUF_CFG accepted, ack on the edge after the strobe edge
        strobe(C_BUF, {32'd20, 32'd110});
        chk("buf_ack_early", 64'(status[3]), 64'd0);
        chk("buf_busy", 64'(status[2]), 64'd1);
        @(posedge clk); #1;
        chk("buf_ack", 64'(status[3]), 64'd1);
        chk("buf_pre", 64'(pre_trigger_count), 64'd20);
        chk("buf_total", 64'(total_sample_count), 64'd110);
        chk("buf_err", 64'(status[4]), 64'd0);
        ack_cmd();

        // BUF_CFG rejected (pre > total), total == 0 rejected, then NOP clears error
        issue(C_BUF, {32'd200, 32'd110});
        chk("bufrej_err", 64'(status[4]), 64'd1);
        chk("bufrej_pre", 64'(pre_trigger_count), 64'd20);
        chk("bufrej_total", 64'(total_sample_count), 64'd110);
        ack_cmd();
        chk("err_sticky", 64'(status[4]), 64'd1);
        issue(C_BUF, {32'd0, 32'd0});
        chk("buf0_err", 64'(status[4]), 64'd1);
        ack_cmd();
        issue(C_NOP, 64'h0);
        chk("nop_clr_err", 64'(status[4]), 64'd0);
        ack_cmd();

        // TRIG_CFG accepted, then edge_ch = 16 rejected
        issue(C_TRIG, {8'h07, 8'd2, 16'hFFFA, 16'hFFFF, 16'hCC9D});
        chk("trig_err", 64'(status[4]), 64'd0);
        chk("trig_pat", 64'(pattern), 64'hCC9D);
        chk("trig_act", 64'(active_ch), 64'hFFFF);
        chk("trig_dc", 64'(dont_care), 64'hFFFA);
        chk("trig_ech", 64'(edge_ch), 64'd2);
        chk("trig_bits", 64'({edge_type, edge_en, pattern_en}), 64'd7);
        ack_cmd();
        issue(C_TRIG, {8'h00, 8'd16, 16'h1111, 16'h2222, 16'h3333});
        chk("trig16_err", 64'(status[4]), 64'd1);
        chk("trig16_pat", 64'(pattern), 64'hCC9D);
        chk("trig16_ech", 64'(edge_ch), 64'd2);
        ack_cmd();

        // START with and without cap_idle
        issue(C_START, 64'h0);
        @(posedge clk); #1;
        chk("start_cnt", 64'(n_start), 64'd1);
        chk("start_err", 64'(status[4]), 64'd0);
        ack_cmd();
        @(negedge clk); cap_idle = 1'b0;
        issue(C_START, 64'h0);
        @(posedge clk); #1;
        chk("start_busy_cnt", 64'(n_start), 64'd1);
        chk("start_busy_err", 64'(status[4]), 64'd1);
        chk("cap_idle_lo", 64'(status[0]), 64'd0);
        ack_cmd();
        issue(C_BUF, {32'd1, 32'd2});
        chk("buf_notidle_err", 64'(status[4]), 64'd1);
        chk("buf_notidle_pre", 64'(pre_trigger_count), 64'd20);
        ack_cmd();
        @(negedge clk); cap_idle = 1'b1; cap_triggered = 1'b1; trigger_sample = 32'd37;
        chk("trig_copy_lat", 64'(status[1]), 64'd0);
        @(posedge clk); #1;
        chk("trig_copy", 64'(status[1]), 64'd1);

        // Register reads
        issue(C_RDT, 64'h0);
        chk("rdtrig", regOut, 64'd37);
        ack_cmd();
        trace_size = 32'd880;
        issue(C_RDS, 64'h0);
        chk("rdsize", regOut, 64'd880);
        ack_cmd();
        chk("regout_hold", regOut, 64'd880);
        for (int i = 0; i < 110; i++) begin
            issue(C_RDD, 64'h0);
            chk("rddata", regOut, trace_word(i));
            chk("rddata_err", 64'(status[4]), 64'd0);
            ack_cmd();
        end

        // Read timeout: no valid for RD_TIMEOUT clocks
        resp_en = 1'b0;
        issue(C_RDD, 64'h0);
        chk("to_lat", 64'(lat), 64'd1025);
        chk("to_err", 64'(status[4]), 64'd1);
        chk("to_regout", regOut, 64'h0);
        ack_cmd();

        // Non-ACK strobe during ACK_WAIT
        issue(C_NOP, 64'h0);
        chk("nop_err0", 64'(status[4]), 64'd0);
        strobe(C_NOP, 64'h0);
        chk("ackwait_err", 64'(status[4]), 64'd1);
        chk("ackwait_ack", 64'(status[3]), 64'd1);
        chk("ackwait_busy", 64'(status[2]), 64'd1);
        ack_cmd();

        // RESET command: pulses and config back to defaults
        issue(C_RST, 64'h0);
        @(posedge clk); #1;
        chk("rst_soft_cnt", 64'(n_soft), 64'd1);
        chk("rst_abort_cnt", 64'(n_abort), 64'd1);
        chk("rstcmd_dc", 64'(dont_care), 64'hFFFF);
        chk("rstcmd_pre", 64'(pre_trigger_count), 64'd0);
        ack_cmd();

        // Hardware reset in the middle of WAIT_DATA
        issue(C_TRIG, {8'h00, 8'd5, 16'h00F0, 16'h0F0F, 16'h1234});
        chk("trig2_act", 64'(active_ch), 64'h0F0F);
        ack_cmd();
        strobe(C_RDD, 64'h0);
        repeat (5) @(posedge clk);
        #1;
        chk("wait_busy", 64'(status[2]), 64'd1);
        @(negedge clk); resetn = 1'b0;
        @(posedge clk); #1;
        chk("hrst_busy", 64'(status[2]), 64'd0);
        chk("hrst_ack", 64'(status[3]), 64'd0);
        chk("hrst_act", 64'(active_ch), 64'hFFFF);
        chk("hrst_dc", 64'(dont_care), 64'hFFFF);
        @(negedge clk); resetn = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
